// File: rtl/quad_decoder_vel.sv
// quad_decoder_vel: quadrature encoder front end with position counter and windowed velocity
//   Inputs : clk, rst (sync, active-high), quadA/quadB/quadZ (async pins), mode (00 x1,
//            01 x2, 1x x4), dir_inv, idx_clr_en, clr, err_clr
//   Outputs: count (wrapping position), velocity (signed steps per window), vel_valid
//            (one-cycle update pulse), dir (last step direction), err (sticky illegal move)
//   Build option: define QUAD_FILTER_EN to insert a FILT_LEN-cycle glitch filter after
//   the synchronisers.
module quad_decoder_vel #(
  parameter int CNT_W       = 16,
  parameter int VEL_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 50000,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quadA,
  input  logic             quadB,
  input  logic             quadZ,
  input  logic [1:0]       mode,
  input  logic             dir_inv,
  input  logic             idx_clr_en,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic [VEL_W-1:0] velocity,
  output logic             vel_valid,
  output logic             dir,
  output logic             err
);
  localparam int WW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam logic signed [VEL_W:0] VMAX = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0] VMIN = {2'b11, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W:0] VONE = {{VEL_W{1'b0}}, 1'b1};
  // bit order everywhere: {Z, B, A}
  logic [SYNC_STAGES*3-1:0] r_sync;
  logic [2:0]               w_sync;
  logic [2:0]               w_cur;
  logic [2:0]               r_prev;
  always_ff @(posedge clk)
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES*3-4:0], quadZ, quadB, quadA};
  assign w_sync = r_sync[SYNC_STAGES*3-1 -: 3];
`ifdef QUAD_FILTER_EN
  localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  logic [2:0]    r_filt;
  logic [FW-1:0] r_fcnt [3];
  // a channel's filtered level follows only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (rst) begin
        r_filt[i] <= 1'b0;
        r_fcnt[i] <= '0;
      end else if (w_sync[i] == r_filt[i]) begin
        r_fcnt[i] <= '0;
      end else if (r_fcnt[i] == FW'(FILT_LEN-1)) begin
        r_filt[i] <= w_sync[i];
        r_fcnt[i] <= '0;
      end else begin
        r_fcnt[i] <= r_fcnt[i] + 1'b1;
      end
  assign w_cur = r_filt;
`else
  assign w_cur = w_sync;
`endif
  always_ff @(posedge clk)
    if (rst) r_prev <= '0;
    else     r_prev <= w_cur;
  logic w_a_chg, w_b_chg, w_illegal, w_step, w_up, w_z_rise;
  assign w_a_chg   = w_cur[0] ^ r_prev[0];
  assign w_b_chg   = w_cur[1] ^ r_prev[1];
  assign w_illegal = w_a_chg & w_b_chg;
  // x4: exactly one channel moved; x2: A alone moved; x1: A alone rose
  assign w_step    = mode[1] ? (w_a_chg ^ w_b_chg) :
                     mode[0] ? (w_a_chg & ~w_b_chg) :
                               (w_cur[0] & ~r_prev[0] & ~w_b_chg);
  assign w_up      = w_cur[0] ^ r_prev[1] ^ dir_inv;
  assign w_z_rise  = w_cur[2] & ~r_prev[2];
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      count <= (clr || (idx_clr_en && w_z_rise)) ? '0 :
               w_step ? (w_up ? count + CNT_W'(1) : count - CNT_W'(1)) : count;
      if (w_step) dir <= w_up;
      err   <= w_illegal | (err & ~err_clr);
    end
  logic [WW-1:0]           r_win;
  logic signed [VEL_W:0]   r_acc;
  logic signed [VEL_W:0]   w_sum;
  logic signed [VEL_W:0]   w_sat;
  logic                    w_term;
  // r_acc never leaves [VMIN, VMAX], so one extra bit holds any single-step overshoot
  assign w_sum  = w_step ? (w_up ? r_acc + VONE : r_acc - VONE) : r_acc;
  assign w_sat  = w_sum > VMAX ? VMAX : w_sum < VMIN ? VMIN : w_sum;
  assign w_term = r_win == WW'(SAMPLE_DIV-1);
  always_ff @(posedge clk)
    if (rst) begin
      r_win     <= '0;
      r_acc     <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      r_win     <= w_term ? '0 : r_win + 1'b1;
      r_acc     <= w_term ? '0 : w_sat;
      vel_valid <= w_term;
      if (w_term) velocity <= w_sat[VEL_W-1:0];
    end
endmodule

// File: tb/tb_quad_decoder_vel.sv
// tb_quad_decoder_vel: random and directed checks of quad_decoder_vel against a reference model
module tb_quad_decoder_vel;
  localparam int CW = 16, VW = 6, SS = 2, FL = 4;
`ifdef QUAD_FILTER_EN
  localparam int LAT = SS + FL, HMIN = FL, SD = 200;
`else
  localparam int LAT = SS, HMIN = 1, SD = 100;
`endif
  localparam int VMAX = (1 << (VW-1)) - 1, VMIN = -(1 << (VW-1));
  logic clk = 0, rst = 1, quadA = 0, quadB = 0, quadZ = 0;
  logic dir_inv = 0, idx_clr_en = 0, clr = 0, err_clr = 0;
  logic [1:0] mode = 2'd2;
  logic [CW-1:0] count;
  logic [VW-1:0] velocity;
  logic vel_valid, dir, err;
  always #5 clk = ~clk;
  quad_decoder_vel #(.CNT_W(CW), .VEL_W(VW), .SYNC_STAGES(SS), .SAMPLE_DIV(SD), .FILT_LEN(FL)) dut (
    .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB), .quadZ(quadZ), .mode(mode),
    .dir_inv(dir_inv), .idx_clr_en(idx_clr_en), .clr(clr), .err_clr(err_clr),
    .count(count), .velocity(velocity), .vel_valid(vel_valid), .dir(dir), .err(err));
  int n_chk = 0, n_pass = 0;
  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  // position of an {Z,B,A} sample on the forward Gray cycle 00 -> 10 -> 11 -> 01 (AB)
  function automatic int gpos(logic [2:0] v);
    return v[0] ? (v[1] ? 2 : 1) : (v[1] ? 3 : 0);
  endfunction
  // the decoder sees the pins LAT cycles late; steps are Gray-position differences
  logic [2:0] hist [LAT+1];
  int m_cnt, m_acc, m_vel, m_n;
  bit m_err, m_dir, m_vv, m_on = 1;
  always @(posedge clk) begin
    logic [2:0] cur, prv;
    int d;
    bit stp, up;
    if (rst) begin
      foreach (hist[i]) hist[i] = '0;
      m_cnt = 0; m_acc = 0; m_vel = 0; m_n = 0; m_err = 0; m_dir = 0; m_vv = 0;
    end else begin
      cur = hist[LAT-1];
      prv = hist[LAT];
      d   = (gpos(cur) - gpos(prv) + 4) % 4;
      stp = (d == 1 || d == 3) && (mode >= 2 || (cur[0] != prv[0] && (mode == 1 || cur[0])));
      up  = (d == 1) ^ dir_inv;
      if (clr || (idx_clr_en && cur[2] && !prv[2])) m_cnt = 0;
      else if (stp) m_cnt = (m_cnt + (up ? 1 : -1)) & ((1 << CW) - 1);
      if (stp) m_dir = up;
      m_err = (d == 2) ? 1'b1 : err_clr ? 1'b0 : m_err;
      if (stp) m_acc = up ? (m_acc < VMAX ? m_acc + 1 : VMAX) : (m_acc > VMIN ? m_acc - 1 : VMIN);
      m_n++;
      m_vv = (m_n % SD) == 0;
      if (m_vv) begin
        m_vel = m_acc;
        m_acc = 0;
      end
      for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {quadZ, quadB, quadA};
    end
  end
  always @(negedge clk)
    if (m_on && !rst) begin
      chk("count", count, m_cnt);
      chk("dir", dir, m_dir);
      chk("err", err, m_err);
      chk("vel_valid", vel_valid, m_vv);
      if (m_vv) chk("velocity", $signed(velocity), m_vel);
    end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic mv(bit fwd);
    int p;
    p = (gpos({1'b0, quadB, quadA}) + (fwd ? 1 : 3)) % 4;
    quadA = (p == 1 || p == 2);
    quadB = (p >= 2);
  endtask
  task automatic do_rst;
    rst = 1;
    cyc(3);
    rst = 0;
  endtask
  task automatic pulse_clr;
    clr = 1;
    cyc(1);
    clr = 0;
  endtask
  task automatic wait_vv(int lim, output int v);
    int k = 0;
    cyc(1);
    while (!vel_valid && k < lim) begin
      cyc(1);
      k++;
    end
    chk("vv_seen", vel_valid, 1);
    v = $signed(velocity);
  endtask
  initial begin
    int v, k, vlast, e;
    do_rst;
    chk("rst_count", count, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    chk("rst_vv", vel_valid, 0);
    chk("rst_vel", $signed(velocity), 0);
    mode = 2;
    repeat (8) begin mv(1); cyc(HMIN + 1); end
    cyc(LAT + 3);
    chk("x4_fwd_count", count, 8);
    chk("x4_fwd_dir", dir, 1);
    chk("x4_fwd_err", err, 0);
    pulse_clr;
    mode = 0;
    repeat (4) begin mv(0); cyc(HMIN + 1); end
    cyc(LAT + 3);
    chk("x1_rev_count", count, 'hFFFF);
    chk("x1_rev_dir", dir, 0);
    pulse_clr;
    mode = 1;
    repeat (4) begin mv(0); cyc(HMIN + 1); end
    cyc(LAT + 3);
    chk("x2_rev_count", count, 'hFFFE);
    mode = 2;
    quadA = ~quadA;
    quadB = ~quadB;
    cyc(HMIN + LAT + 3);
    chk("illegal_count", count, 'hFFFE);
    chk("illegal_err", err, 1);
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    cyc(1);
    chk("err_clr", err, 0);
    quadA = 0;
    quadB = 0;
    cyc(HMIN + 1);
    do_rst;
    repeat (30) begin mv(1); cyc(HMIN + 1); end
    wait_vv(SD + 10, v);
    chk("vel_fwd30", v, 30);
    repeat (5) begin mv(0); cyc(HMIN + 1); end
    wait_vv(SD + 10, v);
    chk("vel_rev5", v, -5);
    cyc(37);
    do_rst;
    k = 0;
    while (!vel_valid && k < 3 * SD) begin cyc(1); k++; end
    chk("rst_window_len", k, SD);
    pulse_clr;
    repeat (37) begin mv(1); cyc(HMIN + 1); end
    cyc(LAT + 3);
    chk("idx_pre_count", count, 37);
    idx_clr_en = 1;
    mv(1);
    quadZ = 1;
    cyc(HMIN + LAT + 3);
    chk("idx_clear", count, 0);
    quadZ = 0;
    cyc(HMIN + 1);
    idx_clr_en = 0;
    mv(1);
    quadZ = 1;
    cyc(HMIN + LAT + 3);
    chk("idx_disabled", count, 1);
    quadZ = 0;
    cyc(HMIN + 1);
    vlast = 0;
    for (int j = 0; j < 2 * SD + 20; j++) begin
      if (j % HMIN == 0) mv(1);
      cyc(1);
      if (vel_valid) vlast = $signed(velocity);
    end
    chk("vel_sat_pos", vlast, VMAX);
    dir_inv = 1;
    for (int j = 0; j < 2 * SD + 20; j++) begin
      if (j % HMIN == 0) mv(1);
      cyc(1);
      if (vel_valid) vlast = $signed(velocity);
    end
    chk("vel_sat_neg", vlast, VMIN);
    for (int j = 0; j < 1500; j++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      mv(1'($urandom_range(0, 1)));
      else if (r < 75) begin quadA = ~quadA; quadB = ~quadB; end
      else if (r < 82) quadZ = ~quadZ;
      else if (r < 86) mode = 2'($urandom_range(0, 3));
      else if (r < 89) dir_inv = ~dir_inv;
      else if (r < 92) idx_clr_en = ~idx_clr_en;
      else if (r < 93) do_rst;
      clr = ($urandom_range(0, 49) == 0);
      err_clr = ($urandom_range(0, 19) == 0);
      cyc(HMIN + $urandom_range(0, 2));
      clr = 0;
      err_clr = 0;
    end
`ifdef QUAD_FILTER_EN
    m_on = 0;
    mode = 2;
    dir_inv = 0;
    idx_clr_en = 0;
    cyc(LAT + 3);
    pulse_clr;
    cyc(1);
    quadA = ~quadA;
    cyc(2);
    quadA = ~quadA;
    cyc(LAT + 5);
    chk("glitch_count", count, 0);
    e = (gpos({1'b0, quadB, ~quadA}) - gpos({1'b0, quadB, quadA}) + 4) % 4 == 1 ? 1 : 'hFFFF;
    quadA = ~quadA;
    cyc(6 + LAT + 3);
    chk("level_count", count, e);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
